// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Merges ALU and load-unit writeback requests onto one registered write port,
// and keeps a busy scoreboard of destinations reserved at issue but not yet written back.
module regfile_write_arbiter #(
    parameter int RR_ENABLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    input  logic [2:0]  lsu_pattern,
    output logic        lsu_ready,
    input  logic        reserve_valid,
    input  logic [4:0]  reserve_rd,
    output logic        rf_wr_enable,
    output logic [4:0]  rf_wr_address,
    output logic [31:0] rf_wr_data,
    output logic [2:0]  rf_write_pattern,
    output logic [31:0] busy_mask
);

    // Write patterns understood by the register memory.
    localparam logic [2:0] REGISTER_WRITE_WORD          = 3'd0;
    localparam logic [2:0] REGISTER_WRITE_HALF_SIGNED   = 3'd1;
    localparam logic [2:0] REGISTER_WRITE_HALF_UNSIGNED = 3'd2;
    localparam logic [2:0] REGISTER_WRITE_BYTE_SIGNED   = 3'd3;
    localparam logic [2:0] REGISTER_WRITE_BYTE_UNSIGNED = 3'd4;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    grant_t      last_grant_reg;
    logic        rf_wr_enable_reg;
    logic [4:0]  rf_wr_address_reg;
    logic [31:0] rf_wr_data_reg;
    logic [2:0]  rf_write_pattern_reg;
    logic [31:0] busy_mask_reg;

    logic        alu_preferred;
    logic        alu_fire;
    logic        lsu_fire;
    logic        xfer;
    logic [4:0]  xfer_rd;
    logic [31:0] xfer_data;
    logic [2:0]  xfer_pattern;
    logic [31:0] clear_mask;
    logic [31:0] set_mask;
    logic [31:0] busy_mask_next;

    // Grant selection: ALU wins a conflict only in round-robin mode when the LSU went last.
    // Ready is held low throughout reset so nothing is accepted while the port is cleared.
    always_comb begin
        alu_preferred = (RR_ENABLE != 0) && (last_grant_reg == GRANT_LSU);
        alu_ready     = rst_n && alu_valid && (!lsu_valid || alu_preferred);
        lsu_ready     = rst_n && lsu_valid && !(alu_valid && alu_preferred);
        alu_fire      = alu_valid && alu_ready;
        lsu_fire      = lsu_valid && lsu_ready;
        xfer          = alu_fire || lsu_fire;
    end

    // Mux the winning request onto the write-port inputs; ALU results are always full words.
    always_comb begin
        xfer_rd      = alu_rd;
        xfer_data    = alu_data;
        xfer_pattern = REGISTER_WRITE_WORD;
        if (lsu_fire) begin
            xfer_rd      = lsu_rd;
            xfer_data    = lsu_data;
            xfer_pattern = lsu_pattern;
        end
    end

    // Scoreboard update: a reservation beats a same-edge clear, and x0 is never busy.
    always_comb begin
        clear_mask     = xfer ? (32'd1 << xfer_rd) : 32'd0;
        set_mask       = reserve_valid ? (32'd1 << reserve_rd) : 32'd0;
        busy_mask_next = ((busy_mask_reg & ~clear_mask) | set_mask) & ~32'd1;
    end

    // Round-robin history only moves on a completed transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= GRANT_LSU;
        end else if (alu_fire) begin
            last_grant_reg <= GRANT_ALU;
        end else if (lsu_fire) begin
            last_grant_reg <= GRANT_LSU;
        end
    end

    // Registered write port: enable pulses per transfer (suppressed for x0); address/data/pattern hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_enable_reg     <= 1'b0;
            rf_wr_address_reg    <= 5'd0;
            rf_wr_data_reg       <= 32'd0;
            rf_write_pattern_reg <= REGISTER_WRITE_WORD;
        end else begin
            rf_wr_enable_reg <= xfer && (xfer_rd != 5'd0);
            if (xfer) begin
                rf_wr_address_reg    <= xfer_rd;
                rf_wr_data_reg       <= xfer_data;
                rf_write_pattern_reg <= xfer_pattern;
            end
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_mask_reg <= 32'd0;
        end else begin
            busy_mask_reg <= busy_mask_next;
        end
    end

    assign rf_wr_enable     = rf_wr_enable_reg;
    assign rf_wr_address    = rf_wr_address_reg;
    assign rf_wr_data       = rf_wr_data_reg;
    assign rf_write_pattern = rf_write_pattern_reg;
    assign busy_mask        = busy_mask_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: a round-robin and a fixed-priority
// instance share stimulus; a small register-memory model consumes the RR write port.
module tb_regfile_write_arbiter;

    localparam logic [2:0] PAT_WORD = 3'd0;
    localparam logic [2:0] PAT_HS   = 3'd1;
    localparam logic [2:0] PAT_HU   = 3'd2;
    localparam logic [2:0] PAT_BS   = 3'd3;
    localparam logic [2:0] PAT_BU   = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = 5'd0;
    logic [31:0] alu_data = 32'd0;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = 5'd0;
    logic [31:0] lsu_data = 32'd0;
    logic [2:0]  lsu_pattern = 3'd0;
    logic        reserve_valid = 1'b0;
    logic [4:0]  reserve_rd = 5'd0;

    logic        rr_alu_ready, rr_lsu_ready, rr_we;
    logic [4:0]  rr_addr;
    logic [31:0] rr_data, rr_busy;
    logic [2:0]  rr_pat;
    logic        fp_alu_ready, fp_lsu_ready, fp_we;
    logic [4:0]  fp_addr;
    logic [31:0] fp_data, fp_busy;
    logic [2:0]  fp_pat;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.RR_ENABLE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(rr_alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_pattern(lsu_pattern),
        .lsu_ready(rr_lsu_ready),
        .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
        .rf_wr_enable(rr_we), .rf_wr_address(rr_addr), .rf_wr_data(rr_data),
        .rf_write_pattern(rr_pat), .busy_mask(rr_busy)
    );

    regfile_write_arbiter #(.RR_ENABLE(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(fp_alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_pattern(lsu_pattern),
        .lsu_ready(fp_lsu_ready),
        .reserve_valid(reserve_valid), .reserve_rd(reserve_rd),
        .rf_wr_enable(fp_we), .rf_wr_address(fp_addr), .rf_wr_data(fp_data),
        .rf_write_pattern(fp_pat), .busy_mask(fp_busy)
    );

    // Register memory model: commits on the edge after the write port is driven.
    logic [31:0] mem [32];
    int wr_count = 0;
    int wr0_count = 0;

    function automatic logic [31:0] extend(input logic [2:0] pat, input logic [31:0] d);
        case (pat)
            PAT_HS:  return {{16{d[15]}}, d[15:0]};
            PAT_HU:  return {16'd0, d[15:0]};
            PAT_BS:  return {{24{d[7]}}, d[7:0]};
            PAT_BU:  return {24'd0, d[7:0]};
            default: return d;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rr_we) begin
            wr_count <= wr_count + 1;
            if (rr_addr == 5'd0) wr0_count <= wr0_count + 1;
            mem[rr_addr] <= extend(rr_pat, rr_data);
        end
    end

    function automatic logic [31:0] rf_read(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic [2:0]  lpat;
        logic        rv;
        logic [4:0]  rrd;
        logic        e_ar;
        logic        e_lr;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [2:0]  e_pat;
        logic [31:0] e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] adata,
        input logic lv, input logic [4:0] lrd, input logic [31:0] ldata, input logic [2:0] lpat,
        input logic rv, input logic [4:0] rrd,
        input logic e_ar, input logic e_lr, input logic e_we, input logic [4:0] e_addr,
        input logic [31:0] e_data, input logic [2:0] e_pat, input logic [31:0] e_busy);
        vec_t v;
        v.av = av; v.ard = ard; v.adata = adata;
        v.lv = lv; v.lrd = lrd; v.ldata = ldata; v.lpat = lpat;
        v.rv = rv; v.rrd = rrd;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_we = e_we; v.e_addr = e_addr;
        v.e_data = e_data; v.e_pat = e_pat; v.e_busy = e_busy;
        return v;
    endfunction

    localparam int NV = 14;
    vec_t vecs [NV];
    int   wc_before;

    initial begin
        //             av ard    adata         lv lrd    ldata         lpat     rv rrd   ar lr we addr   data          pat       busy
        vecs[0]  = mk(0, 5'h00, 32'h0,        0, 5'h00, 32'h0,        PAT_WORD, 0, 5'd0, 0, 0, 0, 5'h00, 32'h0,        PAT_WORD, 32'h0);
        vecs[1]  = mk(1, 5'h0A, 32'hABCDEFAB, 0, 5'h00, 32'h0,        PAT_WORD, 0, 5'd0, 1, 0, 1, 5'h0A, 32'hABCDEFAB, PAT_WORD, 32'h0);
        vecs[2]  = mk(0, 5'h00, 32'h0,        1, 5'h0F, 32'hABCDEFFA, PAT_BU,   0, 5'd0, 0, 1, 1, 5'h0F, 32'hABCDEFFA, PAT_BU,   32'h0);
        vecs[3]  = mk(1, 5'h01, 32'h11111111, 1, 5'h02, 32'h22222222, PAT_WORD, 0, 5'd0, 1, 0, 1, 5'h01, 32'h11111111, PAT_WORD, 32'h0);
        vecs[4]  = mk(1, 5'h01, 32'h11111111, 1, 5'h02, 32'h22222222, PAT_WORD, 0, 5'd0, 0, 1, 1, 5'h02, 32'h22222222, PAT_WORD, 32'h0);
        vecs[5]  = mk(1, 5'h01, 32'h11111111, 1, 5'h02, 32'h22222222, PAT_WORD, 0, 5'd0, 1, 0, 1, 5'h01, 32'h11111111, PAT_WORD, 32'h0);
        vecs[6]  = mk(1, 5'h00, 32'hEEEEEEEE, 0, 5'h00, 32'h0,        PAT_WORD, 0, 5'd0, 1, 0, 0, 5'h00, 32'h0,        PAT_WORD, 32'h0);
        vecs[7]  = mk(0, 5'h00, 32'h0,        0, 5'h00, 32'h0,        PAT_WORD, 1, 5'd5, 0, 0, 0, 5'h00, 32'h0,        PAT_WORD, 32'h00000020);
        vecs[8]  = mk(0, 5'h00, 32'h0,        1, 5'h05, 32'h55555555, PAT_WORD, 1, 5'd5, 0, 1, 1, 5'h05, 32'h55555555, PAT_WORD, 32'h00000020);
        vecs[9]  = mk(0, 5'h00, 32'h0,        1, 5'h05, 32'h66666666, PAT_WORD, 0, 5'd0, 0, 1, 1, 5'h05, 32'h66666666, PAT_WORD, 32'h0);
        vecs[10] = mk(0, 5'h00, 32'h0,        0, 5'h00, 32'h0,        PAT_WORD, 1, 5'd0, 0, 0, 0, 5'h00, 32'h0,        PAT_WORD, 32'h0);
        vecs[11] = mk(0, 5'h00, 32'h0,        0, 5'h00, 32'h0,        PAT_WORD, 1, 5'd3, 0, 0, 0, 5'h00, 32'h0,        PAT_WORD, 32'h00000008);
        vecs[12] = mk(1, 5'h07, 32'h00000077, 0, 5'h00, 32'h0,        PAT_WORD, 0, 5'd0, 1, 0, 1, 5'h07, 32'h00000077, PAT_WORD, 32'h00000008);
        vecs[13] = mk(1, 5'h09, 32'h99999999, 1, 5'h03, 32'hCAFE1233, PAT_BU,   0, 5'd0, 0, 1, 1, 5'h03, 32'hCAFE1233, PAT_BU,   32'h0);

        // Reset state, with requests already asserted.
        alu_valid = 1'b1;
        lsu_valid = 1'b1;
        #12;
        check("reset_alu_ready", {31'd0, rr_alu_ready}, 32'd0);
        check("reset_lsu_ready", {31'd0, rr_lsu_ready}, 32'd0);
        check("reset_we", {31'd0, rr_we}, 32'd0);
        check("reset_addr", {27'd0, rr_addr}, 32'd0);
        check("reset_data", rr_data, 32'd0);
        check("reset_pat", {29'd0, rr_pat}, {29'd0, PAT_WORD});
        check("reset_busy", rr_busy, 32'd0);
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_rd = vecs[i].ard; alu_data = vecs[i].adata;
            lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ldata;
            lsu_pattern = vecs[i].lpat;
            reserve_valid = vecs[i].rv; reserve_rd = vecs[i].rrd;
            #1;
            check($sformatf("v%0d_alu_ready", i), {31'd0, rr_alu_ready}, {31'd0, vecs[i].e_ar});
            check($sformatf("v%0d_lsu_ready", i), {31'd0, rr_lsu_ready}, {31'd0, vecs[i].e_lr});
            // Fixed priority: LSU always wins, ALU only when alone.
            check($sformatf("v%0d_fp_alu_ready", i), {31'd0, fp_alu_ready}, {31'd0, vecs[i].av & ~vecs[i].lv});
            check($sformatf("v%0d_fp_lsu_ready", i), {31'd0, fp_lsu_ready}, {31'd0, vecs[i].lv});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_we", i), {31'd0, rr_we}, {31'd0, vecs[i].e_we});
            check($sformatf("v%0d_busy", i), rr_busy, vecs[i].e_busy);
            if (vecs[i].e_we) begin
                check($sformatf("v%0d_addr", i), {27'd0, rr_addr}, {27'd0, vecs[i].e_addr});
                check($sformatf("v%0d_data", i), rr_data, vecs[i].e_data);
                check($sformatf("v%0d_pat", i), {29'd0, rr_pat}, {29'd0, vecs[i].e_pat});
            end
            $display("[TB] vec %0d: alu_v=%0d lsu_v=%0d rsv=%0d -> we=%0d addr=0x%02h data=0x%08h pat=%0d busy=0x%08h",
                     i, alu_valid, lsu_valid, reserve_valid, rr_we, rr_addr, rr_data, rr_pat, rr_busy);
        end

        // Idle cycle so the last registered write commits to the memory model.
        @(negedge clk);
        alu_valid = 1'b0; lsu_valid = 1'b0; reserve_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_we", {31'd0, rr_we}, 32'd0);
        check("idle_addr_hold", {27'd0, rr_addr}, 32'h03);
        check("idle_data_hold", rr_data, 32'hCAFE1233);
        @(posedge clk);
        #1;
        check("mem_x0A_word", rf_read(5'h0A), 32'hABCDEFAB);
        check("mem_x0F_byte_unsigned", rf_read(5'h0F), 32'h000000FA);
        check("mem_x07", rf_read(5'h07), 32'h00000077);
        check("mem_x03_byte_unsigned", rf_read(5'h03), 32'h00000033);
        check("mem_x05_last", rf_read(5'h05), 32'h66666666);
        check("mem_x0_writes", wr0_count, 32'd0);
        $display("[TB] memory: x0A=0x%08h x0F=0x%08h x03=0x%08h writes=%0d", rf_read(5'h0A), rf_read(5'h0F), rf_read(5'h03), wr_count);

        // Reset dropped between an accepted transfer and its commit edge.
        @(negedge clk);
        reserve_valid = 1'b1; reserve_rd = 5'h0C;
        @(negedge clk);
        reserve_rd = 5'h0D;
        alu_valid = 1'b1; alu_rd = 5'h0C; alu_data = 32'hC0C0C0C0;
        #1;
        check("rst_seq_alu_ready", {31'd0, rr_alu_ready}, 32'd1);
        @(posedge clk);
        #1;
        check("rst_seq_we_pending", {31'd0, rr_we}, 32'd1);
        check("rst_seq_busy_pre", rr_busy, 32'h00002000);
        wc_before = wr_count;
        rst_n = 1'b0;
        #1;
        check("rst_async_we", {31'd0, rr_we}, 32'd0);
        check("rst_async_addr", {27'd0, rr_addr}, 32'd0);
        check("rst_async_data", rr_data, 32'd0);
        check("rst_async_pat", {29'd0, rr_pat}, {29'd0, PAT_WORD});
        check("rst_async_busy", rr_busy, 32'd0);
        check("rst_async_alu_ready", {31'd0, rr_alu_ready}, 32'd0);
        $display("[TB] reset mid-op: we=%0d busy=0x%08h alu_ready=%0d", rr_we, rr_busy, rr_alu_ready);
        alu_valid = 1'b0; reserve_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_no_write", wr_count, wc_before);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_we", {31'd0, rr_we}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
